ee354_divider: RTL and testbench

Sequential unsigned integer divider that serves the Start/Ack request protocol as the responding core. A test bench or top-level controller acts as the requester. The requester presents operands and pulses Start, waits for q_Done, then pulses Ack. The divider computes Quotient and Remainder by binary shift-and-subtract at one bit per enabled clock, exposes one-hot state outputs for display/single-stepping, and honours clock enable (CEN) so a top design can single-step it.

---
 rtl/ee354_divider.sv | 153 +++++++++++++++
 tb/tb_ee354_divider.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ee354_divider.sv
// Sequential unsigned shift-and-subtract divider with a Start/Ack handshake and one-hot state outputs.
// Optional feature macro: DIVIDER_DIV0_EN (adds the Div0 flag and a short-circuit for a zero divisor).
module ee354_divider #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1),
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             CEN,
    input  logic             Start,
    input  logic             Ack,
    input  logic [WIDTH-1:0] Xin,
    input  logic [WIDTH-1:0] Yin,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic [CW-1:0]    i_count,
    output logic             q_I,
    output logic             q_Sub,
`ifdef DIVIDER_DIV0_EN
    output logic             Div0,
`endif
    output logic             q_Done
);

    typedef enum logic [2:0] {
        S_I    = 3'b001,
        S_SUB  = 3'b010,
        S_DONE = 3'b100
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`ifdef DIVIDER_DIV0_EN
    logic             div0_q, div0_d;
`endif

    logic [IW-1:0]    k_s;
    logic [WIDTH:0]   t_s;
    logic             ge_s;
    logic [WIDTH-1:0] diff_s;

    // Trial subtraction datapath for the current bit position k = WIDTH-1-i_count.
    always_comb begin
        k_s    = IW'(WIDTH - 1) - cnt_q[IW-1:0];
        t_s    = {rem_q, x_q[k_s]};
        ge_s   = (t_s >= {1'b0, y_q});
        // T-Y is always below Y, so the low WIDTH bits of the difference are exact.
        diff_s = t_s[WIDTH-1:0] - y_q;
    end

    // Next-state and next-data logic; CEN gating is applied in the register block.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
`ifdef DIVIDER_DIV0_EN
        div0_d  = div0_q;
`endif
        case (state_q)
            S_I: begin
                if (Start) begin
                    x_d     = Xin;
                    y_d     = Yin;
                    quot_d  = {WIDTH{1'b0}};
                    rem_d   = {WIDTH{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    state_d = S_SUB;
`ifdef DIVIDER_DIV0_EN
                    div0_d  = 1'b0;
                    if (Yin == {WIDTH{1'b0}}) begin
                        state_d = S_DONE;
                        div0_d  = 1'b1;
                        quot_d  = {WIDTH{1'b1}};
                        rem_d   = Xin;
                    end else begin
                        state_d = S_SUB;
                    end
`endif
                end else begin
                    state_d = S_I;
                end
            end
            S_SUB: begin
                if (ge_s) begin
                    rem_d = diff_s;
                end else begin
                    rem_d = t_s[WIDTH-1:0];
                end
                quot_d[k_s] = ge_s;
                cnt_d       = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SUB;
                end
            end
            S_DONE: begin
                if (Ack) begin
                    state_d = S_I;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_I;
            end
        endcase
    end

    // State and data registers; CEN=0 freezes everything.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_I;
            x_q     <= {WIDTH{1'b0}};
            y_q     <= {WIDTH{1'b0}};
            quot_q  <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
`ifdef DIVIDER_DIV0_EN
            div0_q  <= 1'b0;
`endif
        end else if (CEN) begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
`ifdef DIVIDER_DIV0_EN
            div0_q  <= div0_d;
`endif
        end
    end

    assign Quotient  = quot_q;
    assign Remainder = rem_q;
    assign i_count   = cnt_q;
    assign q_I       = (state_q == S_I);
    assign q_Sub     = (state_q == S_SUB);
    assign q_Done    = (state_q == S_DONE);
`ifdef DIVIDER_DIV0_EN
    assign Div0      = div0_q;
`endif

endmodule

// File: tb/tb_ee354_divider.sv
// Directed bench for ee354_divider: expected quotient/remainder pairs are queued at Start
// and popped when the divider reaches q_Done.
module tb_ee354_divider;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic         Clk   = 1'b0;
    logic         Reset = 1'b0;
    logic         CEN   = 1'b1;
    logic         Start = 1'b0;
    logic         Ack   = 1'b0;
    logic [W-1:0] Xin   = 8'd0;
    logic [W-1:0] Yin   = 8'd0;
    logic [W-1:0] Quotient, Remainder;
    logic [CW-1:0] i_count;
    logic         q_I, q_Sub, q_Done;
`ifdef DIVIDER_DIV0_EN
    logic         Div0;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
    } res_t;
    res_t sb[$];

    ee354_divider #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .CEN       (CEN),
        .Start     (Start),
        .Ack       (Ack),
        .Xin       (Xin),
        .Yin       (Yin),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .i_count   (i_count),
        .q_I       (q_I),
        .q_Sub     (q_Sub),
`ifdef DIVIDER_DIV0_EN
        .Div0      (Div0),
`endif
        .q_Done    (q_Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // One full transaction; freeze_at>=0 drops CEN for 5 clocks after that many q_Sub clocks,
    // hold_test exercises Start held in q_Done and Ack held in q_I.
    task automatic run(input logic [W-1:0] x, input logic [W-1:0] y,
                       input int freeze_at, input bit hold_test);
        res_t e;
        res_t got;
        int n;
        bit skip;
        logic [CW-1:0] c_hold;
        logic [W-1:0] q_hold;
        skip = 1'b0;
`ifdef DIVIDER_DIV0_EN
        skip = (y == 8'd0);
`endif
        if (y == 8'd0) begin
            e.q = 8'hFF;
            e.r = x;
        end else begin
            e.q = x / y;
            e.r = x % y;
        end
        sb.push_back(e);
        Xin = x; Yin = y; Start = 1'b1;
        step();
        Start = 1'b0;
        Xin = 8'($urandom);
        Yin = 8'($urandom);
        check("sub_entry", q_Sub, !skip);
        n = 0;
        while (!q_Done && n < 20) begin
            if (n == freeze_at) begin
                c_hold = i_count;
                q_hold = Quotient;
                CEN = 1'b0;
                repeat (5) begin
                    step();
                    check("frz_cnt", i_count, c_hold);
                    check("frz_q", Quotient, q_hold);
                    check("frz_st", {q_I, q_Sub, q_Done}, 3'b010);
                end
                CEN = 1'b1;
            end
            step();
            n++;
        end
        check("sub_len", n, skip ? 0 : W);
        check("done_st", {q_I, q_Sub, q_Done}, 3'b001);
        got = {Quotient, Remainder};
        e = sb.pop_front();
        check("quot", got.q, e.q);
        check("rem", got.r, e.r);
        check("cnt_done", i_count, skip ? 0 : W);
`ifdef DIVIDER_DIV0_EN
        check("div0", Div0, (y == 8'd0));
`endif
        if (hold_test) begin
            Start = 1'b1;
            repeat (3) begin
                step();
                check("start_in_done", {q_I, q_Sub, q_Done}, 3'b001);
                check("start_in_done_q", Quotient, e.q);
            end
            Ack = 1'b1;
            step();
            Start = 1'b0;
            check("ack_with_start", {q_I, q_Sub, q_Done}, 3'b100);
            repeat (2) begin
                step();
                check("ack_in_idle", {q_I, q_Sub, q_Done}, 3'b100);
                check("ack_in_idle_r", Remainder, e.r);
            end
            Ack = 1'b0;
        end else begin
            step();
            check("done_hold", {q_I, q_Sub, q_Done}, 3'b001);
            Ack = 1'b1;
            step();
            Ack = 1'b0;
            check("ack_idle", {q_I, q_Sub, q_Done}, 3'b100);
            check("idle_q", Quotient, e.q);
            check("idle_r", Remainder, e.r);
            check("idle_cnt", i_count, skip ? 0 : W);
        end
    endtask

    initial begin
        #12;
        check("rst_st", {q_I, q_Sub, q_Done}, 3'b100);
        check("rst_q", Quotient, 0);
        check("rst_r", Remainder, 0);
        check("rst_cnt", i_count, 0);
        Reset = 1'b1;
        step();
        check("idle_after_rst", {q_I, q_Sub, q_Done}, 3'b100);

        run(8'd100, 8'd7, -1, 1'b0);
        run(8'd5, 8'd15, -1, 1'b0);
        run(8'd255, 8'd1, -1, 1'b0);
        run(8'd37, 8'd0, -1, 1'b0);
        run(8'd200, 8'd9, 3, 1'b0);

        // Abort mid-computation with an asynchronous reset
        Xin = 8'd255; Yin = 8'd1; Start = 1'b1;
        step();
        Start = 1'b0;
        step();
        step();
        check("pre_abort_q", Quotient, 8'hC0);
        Reset = 1'b0;
        #1;
        check("abort_st", {q_I, q_Sub, q_Done}, 3'b100);
        check("abort_q", Quotient, 0);
        check("abort_r", Remainder, 0);
        check("abort_cnt", i_count, 0);
        step();
        Reset = 1'b1;
        step();
        check("abort_idle", {q_I, q_Sub, q_Done}, 3'b100);
        run(8'd36, 8'd24, -1, 1'b0);

        run(8'd123, 8'd10, -1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run(8'($urandom), 8'($urandom_range(1, 255)), -1, 1'b0);
        end
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
